// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op encodings for the logic unit
package alu_pkg;

    localparam int LOP_W = 3;

    localparam logic [LOP_W-1:0] LOP_AND   = 3'b000;
    localparam logic [LOP_W-1:0] LOP_OR    = 3'b001;
    localparam logic [LOP_W-1:0] LOP_XOR   = 3'b010;
    localparam logic [LOP_W-1:0] LOP_NOR   = 3'b011;
    localparam logic [LOP_W-1:0] LOP_XNOR  = 3'b100;
    localparam logic [LOP_W-1:0] LOP_NAND  = 3'b101;
    localparam logic [LOP_W-1:0] LOP_ANDN  = 3'b110;
    localparam logic [LOP_W-1:0] LOP_PASSA = 3'b111;

endpackage

// File: rtl/logic_pipe_stage.sv
// rtl/logic_pipe_stage.sv - one valid+payload pipeline register
module logic_pipe_stage #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         vin,
    input  logic [W-1:0] din,
    output logic         vout,
    output logic [W-1:0] dout
);

    // Capture the upstream slot whenever the chain says this stage may move;
    // otherwise hold, so a stalled result stays stable on the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vout <= 1'b0;
            dout <= '0;
        end else if (load) begin
            vout <= vin;
            dout <= din;
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - pipelined bitwise logic unit with valid/ready flow control
module logic_unit_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [LOP_W-1:0] op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic [TAG_W-1:0] out_tag
);

    // Payload layout: {tag, zero, parity, result}
    localparam int PW = WIDTH + TAG_W + 2;

    logic [WIDTH-1:0]  op_res;
    logic [PW-1:0]     stage_in;
    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] adv;
    logic [PW-1:0]     payload [STAGES];

    // Op decode: the whole result is formed here so later stages only shift.
    always_comb begin
        op_res = '0;
        case (op)
            LOP_AND:   op_res = operand1 & operand2;
            LOP_OR:    op_res = operand1 | operand2;
            LOP_XOR:   op_res = operand1 ^ operand2;
            LOP_NOR:   op_res = ~(operand1 | operand2);
            LOP_XNOR:  op_res = ~(operand1 ^ operand2);
            LOP_NAND:  op_res = ~(operand1 & operand2);
            LOP_ANDN:  op_res = operand1 & ~operand2;
            LOP_PASSA: op_res = operand1;
            default:   op_res = '0;
        endcase
    end

    assign stage_in = {in_tag, ~(|op_res), ^op_res, op_res};

    // Advance chain: a stage moves if it is empty or its successor moves,
    // giving a bubble-free combinational ready path from out_ready back to in_ready.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = !valid[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = !valid[k] | adv[k+1];
        end
    end

    assign in_ready = adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic          vin;
        logic [PW-1:0] din;

        if (k == 0) begin : g_first
            assign vin = in_valid;
            assign din = stage_in;
        end else begin : g_rest
            assign vin = valid[k-1];
            assign din = payload[k-1];
        end

        logic_pipe_stage #(
            .W(PW)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .load (adv[k]),
            .vin  (vin),
            .din  (din),
            .vout (valid[k]),
            .dout (payload[k])
        );
    end

    assign out_valid = valid[STAGES-1];
    assign result    = payload[STAGES-1][WIDTH-1:0];
    assign parity    = payload[STAGES-1][WIDTH];
    assign zero      = payload[STAGES-1][WIDTH+1];
    assign out_tag   = payload[STAGES-1][PW-1 -: TAG_W];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - scoreboard bench for logic_unit_pipe
module tb_logic_unit_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] operand1 = '0;
    logic [WIDTH-1:0] operand2 = '0;
    logic [2:0]       op = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;
    logic [TAG_W-1:0] out_tag;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             p;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    logic_unit_pipe #(
        .WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .operand1(operand1), .operand2(operand2), .op(op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .parity(parity), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [WIDTH-1:0] lop(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [2:0] o);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a | b);
            3'd4: return ~(a ^ b);
            3'd5: return ~(a & b);
            3'd6: return a & ~b;
            default: return a;
        endcase
    endfunction

    // Presents one request (entered at posedge+1), waits for acceptance, returns at posedge+1.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] o,
                        input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] r,
                        input logic z, input logic p);
        bit ok;
        exp_t e;
        ok = 0;
        operand1 = a; operand2 = b; op = o; in_tag = t; in_valid = 1'b1;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                e.res = r; e.z = z; e.p = p; e.tag = t;
                sb.push_back(e);
                ok = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) break;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall stability.
    initial begin
        exp_t e;
        bit held;
        logic [WIDTH-1:0] h_res;
        logic [TAG_W-1:0] h_tag;
        logic h_z, h_p;
        held = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 0;
            end else begin
                if (held && out_valid) begin
                    chk("hold_result", 64'(result), 64'(h_res));
                    chk("hold_tag", 64'(out_tag), 64'(h_tag));
                    chk("hold_flags", {62'd0, zero, parity}, {62'd0, h_z, h_p});
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_tag", 64'(out_tag), 64'hFFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("result", 64'(result), 64'(e.res));
                        chk("zero", 64'(zero), 64'(e.z));
                        chk("parity", 64'(parity), 64'(e.p));
                        chk("tag", 64'(out_tag), 64'(e.tag));
                    end
                    held = 0;
                end else if (out_valid) begin
                    held = 1;
                    h_res = result; h_tag = out_tag; h_z = zero; h_p = parity;
                end else begin
                    held = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    logic [WIDTH-1:0] sw_exp [8];
    logic [TAG_W-1:0] bp_tag;
    logic [WIDTH-1:0] ra, rb;
    logic [2:0]       ro;
    exp_t             re;

    initial begin
        sw_exp[0] = 32'h00F0_1234; sw_exp[1] = 32'hFFF0_FFFF;
        sw_exp[2] = 32'hFF00_EDCB; sw_exp[3] = 32'h000F_0000;
        sw_exp[4] = 32'h00FF_1234; sw_exp[5] = 32'hFF0F_EDCB;
        sw_exp[6] = 32'hF000_0000; sw_exp[7] = 32'hF0F0_1234;

        // Reset state
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", {62'd0, zero, parity}, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Op sweep
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(32'hF0F0_1234, 32'h0FF0_FFFF, 3'(i), TAG_W'(i), sw_exp[i],
                 sw_exp[i] == '0, ^sw_exp[i]);
        end
        drain();

        // Flags
        send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b010, 4'hA, 32'h0, 1'b1, 1'b0);
        send(32'h0000_0001, 32'h0000_0000, 3'b001, 4'hB, 32'h1, 1'b0, 1'b1);
        drain();

        // Backpressure: PASS_A so result equals the operand
        out_ready = 1'b0;
        bp_tag = 4'd1;
        for (int c = 0; c < 6; c++) begin
            operand1 = 32'(bp_tag) * 32'h1111_1111; operand2 = 32'h0;
            op = 3'b111; in_tag = bp_tag; in_valid = 1'b1;
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), (c < STAGES) ? 64'd1 : 64'd0);
            if (in_ready) begin
                re.res = 32'(bp_tag) * 32'h1111_1111;
                re.z = 1'b0; re.p = 1'b0; re.tag = bp_tag;
                sb.push_back(re);
                bp_tag = bp_tag + 4'd1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        send(32'h3333_3333, 32'h0, 3'b111, 4'd3, 32'h3333_3333, 1'b0, 1'b0);
        send(32'h4444_4444, 32'h0, 3'b111, 4'd4, 32'h4444_4444, 1'b0, 1'b0);
        drain();

        // Streaming: 16 back-to-back ops
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) begin
                operand1 = 32'h1357_9BDF + 32'(i) * 32'h0101_0101;
                operand2 = 32'hA5A5_0F0F ^ 32'(i << 4);
                op = 3'(i); in_tag = TAG_W'(i); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 16) begin
                chk("stream_in_ready", 64'(in_ready), 64'd1);
                re.res = lop(operand1, operand2, op);
                re.z = (re.res == '0); re.p = ^re.res; re.tag = in_tag;
                sb.push_back(re);
            end
            chk("stream_out_valid", 64'(out_valid),
                (i >= STAGES && i < 16 + STAGES) ? 64'd1 : 64'd0);
            @(posedge clk); #1;
        end
        drain();

        // Random stall
        for (int c = 0; c < 10000; c++) begin
            ra = $urandom; rb = $urandom; ro = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) rb = ra;
            operand1 = ra; operand2 = rb; op = ro;
            in_tag = TAG_W'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready) begin
                re.res = lop(ra, rb, ro);
                re.z = (re.res == '0); re.p = ^re.res; re.tag = in_tag;
                sb.push_back(re);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // Reset mid-flight
        out_ready = 1'b0;
        send(32'h0000_00FF, 32'h0000_000F, 3'b000, 4'd5, 32'h0000_000F, 1'b0, 1'b0);
        send(32'h0000_00F0, 32'h0000_000F, 3'b001, 4'd6, 32'h0000_00FF, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_out_tag", 64'(out_tag), 64'd0);
        sb.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        send(32'h0000_0005, 32'h0000_000A, 3'b001, 4'd9, 32'h0000_000F, 1'b0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
